// File: rtl/gray_counter.sv
// Free-running binary up-counter with synchronous parallel load.
// The output is a registered Gray-code view of the count.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next_s;
  logic [WIDTH-1:0] gray_next_s;

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Next binary count: load has priority over the unconditional increment.
  always_comb begin
    count_next_s = count;
    if (load_en) begin
      count_next_s = data_in;
    end else begin
      count_next_s = count + WIDTH'(1);
    end
  end

  // Gray encoding of the next count, so out is registered with no added latency.
  always_comb begin
    gray_next_s = bin_to_gray(count_next_s);
  end

  // Count and Gray output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {WIDTH{1'b0}};
      out   <= {WIDTH{1'b0}};
    end else begin
      count <= count_next_s;
      out   <= gray_next_s;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: 4-bit instance for the main sequence,
// 8-bit instance for the wider-parameter load and carry case.
module tb_gray_counter;

  logic       clk;
  logic       reset;
  logic [3:0] data4;
  logic       load4;
  logic [3:0] out4;
  logic [7:0] data8;
  logic       load8;
  logic [7:0] out8;

  int tests;
  int failures;

  logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [3:0] prev;

  gray_counter #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data4),
    .load_en (load4),
    .out     (out4)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data8),
    .load_en (load8),
    .out     (out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset    = 1'b0;
    data4    = 4'b0000;
    load4    = 1'b0;
    data8    = 8'h00;
    load8    = 1'b0;

    // Held in reset with the clock running
    tick();
    tick();
    tick();
    check("reset_out4", 32'(out4), 32'h0);
    check("reset_count4", 32'(dut4.count), 32'h0);
    check("reset_out8", 32'(out8), 32'h0);

    // Release, load zero, then count through a full period
    reset = 1'b1;
    load4 = 1'b1;
    data4 = 4'b0000;
    tick();
    check("load0_out", 32'(out4), 32'h0);
    check("load0_count", 32'(dut4.count), 32'h0);
    load4 = 1'b0;
    prev  = out4;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("seq_out_%0d", i), 32'(out4), 32'(gseq[i]));
      check($sformatf("seq_ham_%0d", i), 32'($countones(out4 ^ prev)), 32'd1);
      prev = out4;
    end
    tick();
    check("wrap_out", 32'(out4), 32'h0);
    check("wrap_ham", 32'($countones(out4 ^ prev)), 32'd1);
    check("wrap_count", 32'(dut4.count), 32'h0);

    // Count to 5, then assert reset mid-cycle
    for (int i = 0; i < 5; i++) tick();
    check("pre_async_out", 32'(out4), 32'(4'b0111));
    #2;
    reset = 1'b0;
    #1;
    check("async_out", 32'(out4), 32'h0);
    check("async_count", 32'(dut4.count), 32'h0);
    load4 = 1'b1;
    data4 = 4'b1001;
    tick();
    check("reset_ignores_load", 32'(out4), 32'h0);
    reset = 1'b1;

    // Load nonzero then count on
    data4 = 4'b1001;
    load4 = 1'b1;
    tick();
    check("load9_count", 32'(dut4.count), 32'd9);
    check("load9_out", 32'(out4), 32'(4'b1101));
    load4 = 1'b0;
    tick();
    check("cnt10_out", 32'(out4), 32'(4'b1111));
    check("cnt10_count", 32'(dut4.count), 32'd10);
    tick();
    check("cnt11_out", 32'(out4), 32'(4'b1110));
    tick();
    check("cnt12_out", 32'(out4), 32'(4'b1010));
    check("cnt12_count", 32'(dut4.count), 32'd12);

    // Back-to-back loads
    load4 = 1'b1;
    data4 = 4'b0011;
    tick();
    check("b2b_first_out", 32'(out4), 32'(4'b0010));
    check("b2b_first_count", 32'(dut4.count), 32'd3);
    data4 = 4'b1111;
    tick();
    check("b2b_second_out", 32'(out4), 32'(4'b1000));
    check("b2b_second_count", 32'(dut4.count), 32'd15);
    load4 = 1'b0;
    tick();
    check("b2b_wrap_out", 32'(out4), 32'h0);

    // Load of the maximum value
    load4 = 1'b1;
    data4 = 4'b1111;
    tick();
    check("loadmax_out", 32'(out4), 32'(4'b1000));
    load4 = 1'b0;
    tick();
    check("loadmax_wrap_out", 32'(out4), 32'h0);
    check("loadmax_wrap_count", 32'(dut4.count), 32'h0);

    // Wider instance
    load8 = 1'b1;
    data8 = 8'h7F;
    tick();
    check("w8_load_out", 32'(out8), 32'h40);
    check("w8_load_count", 32'(dut8.count), 32'h7F);
    load8 = 1'b0;
    tick();
    check("w8_carry_count", 32'(dut8.count), 32'h80);
    check("w8_carry_out", 32'(out8), 32'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
